// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult  (with adder cells ha, fa)
//  Purpose  : Unsigned sequential shift-and-add multiplier. One partial
//             product is added per clock through a WIDTH-bit ripple-carry
//             adder built from a half adder (bit 0) and full adders
//             (bits 1..WIDTH-1). Start/done handshake, 2*WIDTH-bit product.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - request, sampled on rising clk while busy=0
//             a, b   - multiplicand / multiplier, captured on accepted start
//             busy   - high while an operation is running
//             done   - one-cycle pulse, p valid in that cycle
//             p      - product a*b, held until the next operation completes
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  ha : half adder cell
// ----------------------------------------------------------------------------
module ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b;
    assign o_co = i_a & i_b;
endmodule

// ----------------------------------------------------------------------------
//  fa : full adder cell
// ----------------------------------------------------------------------------
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// ----------------------------------------------------------------------------
//  seq_mult : sequential multiplier top
// ----------------------------------------------------------------------------
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    // Accumulator without its bit 0: that bit is shifted out on the very
    // next iteration and never reaches the product, so it is not stored.
    // The full 2*WIDTH-bit value is rebuilt in w_acc_nxt.
    logic [2*WIDTH-1:1]     r_acc;
    logic [c_CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]     r_p;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH:0]         w_carry;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic                   w_last;
    logic                   w_accept;

    // ------------------------------------------------------------------
    // Partial product and ripple-carry adder on the upper accumulator half
    // ------------------------------------------------------------------
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    ha u_ha0 (
        .i_a  (r_acc[WIDTH]),
        .i_b  (w_addend[0]),
        .o_s  (w_sum[0]),
        .o_co (w_carry[1])
    );
    assign w_carry[0] = 1'b0;

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_fa
        fa u_fa (
            .i_a  (r_acc[WIDTH+gi]),
            .i_b  (w_addend[gi]),
            .i_ci (w_carry[gi]),
            .o_s  (w_sum[gi]),
            .o_co (w_carry[gi+1])
        );
    end

    // Carry lands in the top bit as everything shifts right by one, so the
    // 2*WIDTH-bit accumulator can never overflow.
    assign w_acc_nxt = {w_carry[WIDTH], w_sum, r_acc[WIDTH-1:1]};

    assign w_last   = (r_cnt == c_LAST);
    // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
    assign w_accept = start && (r_state != S_RUN);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_nxt[2*WIDTH-1:1];
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                // Product is registered on entry to DONE and held afterwards.
                r_p <= w_acc_nxt;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire
